spi_slave_reg_ctrl: RTL
=======================

# spi_slave_reg_ctrl

- Command sequencer behind the SPI slave shifter.
- Decodes the first received byte of each chip-select frame as a command: bit 7 = read (1) / write (0), bits 6:0 = register address.
- Writes: moves the following data byte onto the register-bus write port.
- Reads: fetches register data and hands it to the slave transmit path.
- Sits between the SPI slave (si_*/so_* handshake) and the chip's control/status register file.

## Interface
Parameters:
- NUM_REGS, 16: number of implemented registers; legal range 1..128.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cs  in  1  SPI chip select, active-low; same net that feeds the slave.
- si_data  in  8  received byte from the slave.
- si_done  in  1  one-cycle pulse; si_data is valid.
- so_data  out  8  byte for the slave to transmit.
- so_start  out  1  one-cycle pulse; slave latches so_data.
- so_ready  in  1  slave can accept so_start.
- reg_addr  out  7  register-bus address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; valid the cycle after reg_re.
- addr_err  out  1  one-cycle pulse on any access with address ≥ NUM_REGS.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
States:
- IDLE: cs low → CMD.
- CMD: wait for si_done.
  - Latch addr = si_data[6:0].
  - si_data[7]=1 → RD_FETCH; else → WR_DATA.
- RD_FETCH:
  - In range: assert reg_re one cycle → RD_LOAD.
  - Out of range: no reg_re; addr_err pulse; data forced to 8'h00 → RD_LOAD.
- RD_LOAD:
  - Capture reg_rdata (or 8'h00) into so_data.
  - Wait for so_ready=1, then pulse so_start → RD_SHIFT.
- RD_SHIFT: wait for si_done of the dummy byte the master clocks in; its content is ignored. Then:
  - AUTO_INC_EN defined: increment addr → RD_FETCH.
  - Otherwise → DRAIN.
- WR_DATA: on si_done, commit.
  - In range: reg_we=1, reg_addr=addr, reg_wdata=si_data, all in the same cycle.
  - Out of range: write dropped; addr_err pulse.
  - Next state: AUTO_INC_EN defined → increment addr, stay in WR_DATA; otherwise → DRAIN.
- DRAIN: ignore all bytes until cs high.

Frame boundaries and events:
- cs high in any state → IDLE on the next cycle; no further strobes are issued.
- si_done coincident with cs high: the byte is complete and is processed exactly once (write committed), then → IDLE.
- A read aborted by cs high before so_start: no so_start is issued.

Address rules:
- Auto-increment wraps from NUM_REGS-1 to 0; wrap is not an error.
- Address arithmetic is 7-bit.

Reset values:
- All outputs 0: so_data=8'h00, reg_addr=0, reg_wdata=0.
- addr_err=0, busy=0, state IDLE.
- reset mid-frame aborts the frame silently; no strobe is issued in the reset cycle.

## Timing
- Write: reg_we fires in the same cycle si_done of the data byte is registered by this block, i.e. 1 clk after the si_done pulse.
- Read: so_start ≤ 3 clk after command si_done when so_ready is high (CMD→RD_FETCH→RD_LOAD→start).
- clk must be ≥ 8× sclk so that so_start lands before the first falling sclk edge of the response byte.
- At most one so_start per response byte.
- reg_we and reg_re are mutually exclusive; each is a single-cycle pulse.
- so_data is held stable from so_start until the next so_start.

## Configuration
- SPI_REG_AUTO_INC_EN defined:
  - Burst mode; frames may carry any number of data bytes.
  - Address increments after each data byte, with wrap.
- Undefined:
  - Exactly one data byte per frame.
  - Subsequent bytes are drained with no register access.
  - Write bursts produce exactly one reg_we.

## Structure
- Shared package spi_ctrl_pkg:
  - State enum type.
  - CMD_RD_BIT = 7.
  - ADDR_W = 7.
  - OOR_RDATA = 8'h00.
- Single module with one registered state/datapath block and one next-state block.
- No sub-module is warranted.

## Test plan
- Write 0x05 ← 0xA5 (frame bytes 0x05, 0xA5): exactly one reg_we with addr 5, wdata 0xA5; addr_err stays 0.
- Read 0x83 with reg_rdata=0x3C: reg_re with addr 3; so_start with so_data=0x3C ≤ 3 clk after command si_done; master receives 0x3C on byte 2.
- Out of range, NUM_REGS=16:
  - Read 0x95: no reg_re, one addr_err pulse, master receives 0x00.
  - Write 0x15: no reg_we, one addr_err pulse.
- Burst with AUTO_INC_EN, NUM_REGS=16: write 0x0E, 0x11, 0x22, 0x33 → reg_we at addr 14, 15, 0 with wdata 0x11, 0x22, 0x33. Without the macro: a single reg_we at addr 14.
- Aborts:
  - cs high after command 0x07, before the data byte: no reg_we; busy falls in 1 clk.
  - reset asserted mid-read: so_start suppressed; all outputs 0 next cycle.
- si_done of the data byte coincident with cs rising (write 0x02, 0x5A): reg_we with addr 2, wdata 0x5A issued once, then IDLE.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state type, command-format constants and address helper for the SPI register controller.
package spi_ctrl_pkg;

    localparam int CMD_RD_BIT = 7;
    localparam int ADDR_W = 7;
    localparam logic [7:0] OOR_RDATA = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_FETCH,
        ST_RD_LOAD,
        ST_RD_SHIFT,
        ST_WR_DATA,
        ST_DRAIN
    } state_t;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input int n);
        return (int'(a) == n - 1) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: decodes SPI command bytes into register-bus reads/writes and feeds read data back to the slave.
// Define SPI_REG_AUTO_INC_EN for burst frames with a wrapping address auto-increment after every data byte.
module spi_slave_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic [7:0]        si_data,
    input  logic              si_done,
    output logic [7:0]        so_data,
    output logic              so_start,
    input  logic              so_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              addr_err,
    output logic              busy
);

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_nx;
    logic [7:0]        r_wdata, w_wdata_nx;
    logic [7:0]        r_so_data, w_so_data_nx;
    logic [7:0]        r_buf, w_buf_nx;
    logic [7:0]        w_rdata;
    logic              r_we, w_we_nx;
    logic              r_re, w_re_nx;
    logic              r_err, w_err_nx;
    logic              r_start, w_start_nx;
    logic              r_first, w_first_nx;
    logic              w_fetch;

    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < 8'(NUM_REGS);
    endfunction

    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_reg_addr_nx = r_reg_addr;
        w_wdata_nx    = r_wdata;
        w_so_data_nx  = r_so_data;
        w_buf_nx      = r_buf;
        w_we_nx       = 1'b0;
        w_re_nx       = 1'b0;
        w_err_nx      = 1'b0;
        w_start_nx    = 1'b0;
        w_first_nx    = 1'b0;
        w_fetch       = 1'b0;
        // reg_rdata is only valid on the first RD_LOAD cycle; later cycles use the held copy
        w_rdata       = !in_rng(r_addr) ? OOR_RDATA : (r_first ? reg_rdata : r_buf);
        case (r_state)
            ST_IDLE: w_state_nx = cs ? ST_IDLE : ST_CMD;
            ST_CMD: begin
                if (si_done) begin
                    w_addr_nx  = si_data[ADDR_W-1:0];
                    w_fetch    = si_data[CMD_RD_BIT];
                    w_state_nx = si_data[CMD_RD_BIT] ? ST_RD_FETCH : ST_WR_DATA;
                end
            end
            ST_RD_FETCH: begin
                w_state_nx = ST_RD_LOAD;
                w_first_nx = 1'b1;
            end
            ST_RD_LOAD: begin
                w_buf_nx = w_rdata;
                if (so_ready && !cs) begin
                    w_so_data_nx = w_rdata;
                    w_start_nx   = 1'b1;
                    w_state_nx   = ST_RD_SHIFT;
                end
            end
            ST_RD_SHIFT: begin
                if (si_done) begin
`ifdef SPI_REG_AUTO_INC_EN
                    w_addr_nx  = next_addr(r_addr, NUM_REGS);
                    w_fetch    = 1'b1;
                    w_state_nx = ST_RD_FETCH;
`else
                    w_state_nx = ST_DRAIN;
`endif
                end
            end
            ST_WR_DATA: begin
                if (si_done) begin
                    w_we_nx       = in_rng(r_addr);
                    w_err_nx      = !in_rng(r_addr);
                    w_reg_addr_nx = in_rng(r_addr) ? r_addr : r_reg_addr;
                    w_wdata_nx    = in_rng(r_addr) ? si_data : r_wdata;
`ifdef SPI_REG_AUTO_INC_EN
                    w_addr_nx     = next_addr(r_addr, NUM_REGS);
`else
                    w_state_nx    = ST_DRAIN;
`endif
                end
            end
            ST_DRAIN: w_state_nx = ST_DRAIN;
            default:  w_state_nx = ST_IDLE;
        endcase
        // read strobe and range error issue together with entry into RD_FETCH
        if (w_fetch && !cs) begin
            w_reg_addr_nx = in_rng(w_addr_nx) ? w_addr_nx : r_reg_addr;
            w_re_nx       = in_rng(w_addr_nx);
            w_err_nx      = !in_rng(w_addr_nx);
        end
        if (cs) w_state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_reg_addr <= '0;
            r_wdata    <= '0;
            r_so_data  <= '0;
            r_buf      <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_first    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_reg_addr <= w_reg_addr_nx;
            r_wdata    <= w_wdata_nx;
            r_so_data  <= w_so_data_nx;
            r_buf      <= w_buf_nx;
            r_we       <= w_we_nx;
            r_re       <= w_re_nx;
            r_err      <= w_err_nx;
            r_start    <= w_start_nx;
            r_first    <= w_first_nx;
        end
    end

    assign so_data   = r_so_data;
    assign so_start  = r_start;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign addr_err  = r_err;
    assign busy      = r_state != ST_IDLE;

endmodule
